bypass_ctrl: RTL and testbench
==============================

# bypass_ctrl

Parametrised operand-bypass and interlock controller for the decode/issue stage of the in-order pipeline. It resolves up to NSRC source operands against NSTAGE in-flight writer stages, picking the youngest matching producer. It raises a combinational stall when a producer's data is not yet available, for example a load still in MEM. Resolved operands, the ID/EX valid bit and per-operand forward flags are registered in its own ID/EX operand register. It also keeps a stall-cycle counter and a sticky stall-watchdog error.

## Interface
Reset: one clock; reset is asynchronous and active-high.

Parameters:
- XLEN, 32, operand data width
- NSRC, 2, number of source operands resolved per instruction
- NSTAGE, 2, writer stages; index 0 = youngest (EX/MEM), NSTAGE-1 = oldest (MEM/WB)
- FWD_EN, 1, 1 = full bypass; 0 = bypass only from stage NSTAGE-1, stall on any younger match
- STALL_MAX, 64, consecutive stall cycles that set `err`

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- id_valid  in  1  decode-stage instruction valid
- id_rs_s  in  NSRC*5  source register indices; operand i at [5i+4:5i]
- id_rs_use  in  NSRC  operand i is actually read by this opcode
- id_rs_v  in  NSRC*XLEN  register-file read values
- byp_valid  in  NSTAGE  stage k holds a valid instruction
- byp_regf_we  in  NSTAGE  stage k will write the register file
- byp_rd_s  in  NSTAGE*5  destination index of stage k
- byp_ready  in  NSTAGE  stage k result is final (0 for a load before WB)
- byp_data  in  NSTAGE*XLEN  result value of stage k
- hold  in  1  downstream stall; freeze ID/EX register
- flush  in  1  kill ID/EX contents (branch redirect)
- stall  out  1  combinational; ID/IF must not advance
- ex_valid  out  1  registered ID/EX valid
- ex_rs_v  out  NSRC*XLEN  registered resolved operands
- ex_fwd  out  NSRC  registered; operand i was taken from a bypass stage
- stall_cnt  out  32  bubble-cycle counter
- err  out  1  sticky watchdog error

## Operation
- Per operand i, a stage k matches when all of these hold: byp_valid[k], byp_regf_we[k], byp_rd_s[k]==rs_i, rs_i!=0, id_rs_use[i] and id_valid.
- Only the lowest-index (youngest) matching stage is considered. Older matches are ignored.
- When no stage matches, the operand is id_rs_v[i] and the fwd flag is 0.
- When the youngest match has byp_ready=1 and (FWD_EN=1 or k==NSTAGE-1), the operand is byp_data[k] and the fwd flag is 1.
- Otherwise operand i needs a stall. `stall` is the OR over all operands.
- x0 never matches and never stalls, even when a stage reports rd=0 with regf_we=1.
- ID/EX register update priority, highest first:
  - flush: ex_valid<=0, ex_rs_v<=0, ex_fwd<=0.
  - hold: all ID/EX registers keep their value.
  - id_valid & !stall: capture. ex_valid<=1, resolved operands and flags are latched.
  - else: bubble. ex_valid<=0, ex_rs_v<=0, ex_fwd<=0.
- stall_cnt increments on every cycle with stall=1 & hold=0 & flush=0, and saturates at 32'hFFFF_FFFF.
- An internal run counter counts consecutive cycles with stall=1 and clears when stall=0.
  - err sets when the run counter reaches STALL_MAX.
  - err is sticky and clears only on rst.
  - The run counter saturates at STALL_MAX.

## Timing
- Reset values, applied asynchronously: ex_valid=0, ex_rs_v=0, ex_fwd=0, stall_cnt=0, run counter=0, err=0.
- `stall` is purely combinational from current inputs. It has no reset dependence beyond its inputs.
- Capture latency is 1 cycle. Values resolved in cycle t appear on ex_* in t+1.
- Load-use with NSTAGE=2, FWD_EN=1: stall is exactly 1 cycle. In the next cycle the load sits in stage 1 with ready=1 and forwards.
- Stall asserted while hold=1: stall_cnt does not increment, but the run counter does. ID/EX holds its value.
- Simultaneous flush and hold: flush wins.
- Simultaneous flush and capture: flush wins. The decode instruction is dropped and the upstream redirect handles it.
- Reset asserted mid-stall: all state clears immediately. stall follows the inputs.

## Test plan
- Stage0 rd=5, ready=1, data=0xAAAA0000; stage1 rd=5, data=0x1111; ID rs1=5 -> stall=0, next cycle ex_rs_v[0]=0xAAAA0000, ex_fwd[0]=1. This proves youngest-wins.
- Load in stage0 with rd=7, ready=0; ID rs2=7 -> stall=1 for 1 cycle, ex_valid=0 (bubble), stall_cnt=1. Then the load is in stage1 with ready=1, data=0x55 -> ex_rs_v[1]=0x55.
- FWD_EN=0, stage0 rd=3 ready=1, ID rs1=3 -> stall=1 until stage1 holds it; then forward from stage1. Also rs=0 with stage rd=0, regf_we=1 -> no stall, operand from id_rs_v.
- hold=1 for 3 cycles with a captured operand 0x1234, upstream changing -> ex_rs_v stays 0x1234. flush=1 together with hold -> ex_valid=0 next cycle.
- Persistent unready match for STALL_MAX=4 cycles -> err=1 at cycle 4 and stays 1 after stall clears. Assert rst mid-stall -> all outputs 0 immediately.
- id_rs_use=0 on a matching unready stage -> stall=0, operand = id_rs_v, ex_fwd=0.

Source files
------------

// File: rtl/bypass_ctrl.sv
// Operand bypass / interlock controller for the decode-issue stage.
// Resolves each source operand against in-flight writers and owns the ID/EX operand register.
module bypass_ctrl #(
  parameter int XLEN      = 32,
  parameter int NSRC      = 2,
  parameter int NSTAGE    = 2,
  parameter int FWD_EN    = 1,
  parameter int STALL_MAX = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id_valid,
  input  logic [NSRC*5-1:0]      id_rs_s,
  input  logic [NSRC-1:0]        id_rs_use,
  input  logic [NSRC*XLEN-1:0]   id_rs_v,
  input  logic [NSTAGE-1:0]      byp_valid,
  input  logic [NSTAGE-1:0]      byp_regf_we,
  input  logic [NSTAGE*5-1:0]    byp_rd_s,
  input  logic [NSTAGE-1:0]      byp_ready,
  input  logic [NSTAGE*XLEN-1:0] byp_data,
  input  logic                   hold,
  input  logic                   flush,
  output logic                   stall,
  output logic                   ex_valid,
  output logic [NSRC*XLEN-1:0]   ex_rs_v,
  output logic [NSRC-1:0]        ex_fwd,
  output logic [31:0]            stall_cnt,
  output logic                   err
);

  localparam int RW = $clog2(STALL_MAX + 1);
  localparam logic [RW-1:0] RUN_MAX = RW'(STALL_MAX);

  logic [NSRC-1:0]      op_stall;
  logic [NSRC-1:0]      op_fwd;
  logic [NSRC*XLEN-1:0] op_val;

  generate
    for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
      logic [4:0]      rs;
      logic            qual;
      logic            hit;
      logic            sel_rdy;
      logic            sel_ok;
      logic [XLEN-1:0] sel_data;

      assign rs   = id_rs_s[5*gi +: 5];
      assign qual = id_valid && id_rs_use[gi] && (rs != 5'd0);

      // Scan oldest to youngest so the youngest matching stage overrides.
      always_comb begin
        hit      = 1'b0;
        sel_rdy  = 1'b0;
        sel_ok   = 1'b0;
        sel_data = '0;
        for (int k = NSTAGE - 1; k >= 0; k--) begin
          if (byp_valid[k] && byp_regf_we[k] && (byp_rd_s[5*k +: 5] == rs)) begin
            hit      = 1'b1;
            sel_rdy  = byp_ready[k];
            sel_ok   = (FWD_EN != 0) || (k == NSTAGE - 1);
            sel_data = byp_data[XLEN*k +: XLEN];
          end
        end
      end

      assign op_fwd[gi]                 = qual && hit && sel_rdy && sel_ok;
      assign op_stall[gi]               = qual && hit && !(sel_rdy && sel_ok);
      assign op_val[XLEN*gi +: XLEN]    = op_fwd[gi] ? sel_data : id_rs_v[XLEN*gi +: XLEN];
    end
  endgenerate

  assign stall = |op_stall;

  logic                 ex_valid_q, ex_valid_d;
  logic [NSRC*XLEN-1:0] ex_rs_v_q, ex_rs_v_d;
  logic [NSRC-1:0]      ex_fwd_q, ex_fwd_d;
  logic [31:0]          stall_cnt_q, stall_cnt_d;
  logic [RW-1:0]        run_q, run_d;
  logic                 err_q, err_d;

  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_rs_v_d  = ex_rs_v_q;
    ex_fwd_d   = ex_fwd_q;
    if (flush) begin
      ex_valid_d = 1'b0;
      ex_rs_v_d  = '0;
      ex_fwd_d   = '0;
    end else if (hold) begin
      ex_valid_d = ex_valid_q;
    end else if (id_valid && !stall) begin
      ex_valid_d = 1'b1;
      ex_rs_v_d  = op_val;
      ex_fwd_d   = op_fwd;
    end else begin
      ex_valid_d = 1'b0;
      ex_rs_v_d  = '0;
      ex_fwd_d   = '0;
    end

    stall_cnt_d = stall_cnt_q;
    if (stall && !hold && !flush && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_d = stall_cnt_q + 32'd1;

    // Run length counts every stalled cycle, including held ones.
    if (!stall)
      run_d = '0;
    else if (run_q != RUN_MAX)
      run_d = run_q + 1'b1;
    else
      run_d = run_q;

    err_d = err_q || (run_d == RUN_MAX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q  <= 1'b0;
      ex_rs_v_q   <= '0;
      ex_fwd_q    <= '0;
      stall_cnt_q <= '0;
      run_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_rs_v_q   <= ex_rs_v_d;
      ex_fwd_q    <= ex_fwd_d;
      stall_cnt_q <= stall_cnt_d;
      run_q       <= run_d;
      err_q       <= err_d;
    end
  end

  assign ex_valid  = ex_valid_q;
  assign ex_rs_v   = ex_rs_v_q;
  assign ex_fwd    = ex_fwd_q;
  assign stall_cnt = stall_cnt_q;
  assign err       = err_q;

endmodule

// File: tb/tb_bypass_ctrl.sv
// Scoreboard bench for bypass_ctrl: a full-bypass and a WB-only-bypass instance share stimulus.
// Expectations are tagged with the cycle they apply to; a negedge monitor retires them.
module tb_bypass_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [9:0]  id_rs_s;
  logic [1:0]  id_rs_use;
  logic [63:0] id_rs_v;
  logic [1:0]  byp_valid, byp_regf_we, byp_ready;
  logic [9:0]  byp_rd_s;
  logic [63:0] byp_data;
  logic        hold, flush;

  logic        a_stall, a_ex_valid, a_err;
  logic [63:0] a_ex_rs_v;
  logic [1:0]  a_ex_fwd;
  logic [31:0] a_stall_cnt;
  logic        b_stall, b_ex_valid, b_err;
  logic [63:0] b_ex_rs_v;
  logic [1:0]  b_ex_fwd;
  logic [31:0] b_stall_cnt;

  always #5 clk = ~clk;

  bypass_ctrl #(.XLEN(32), .NSRC(2), .NSTAGE(2), .FWD_EN(1), .STALL_MAX(4)) dut_a (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs_s(id_rs_s), .id_rs_use(id_rs_use),
    .id_rs_v(id_rs_v), .byp_valid(byp_valid), .byp_regf_we(byp_regf_we), .byp_rd_s(byp_rd_s),
    .byp_ready(byp_ready), .byp_data(byp_data), .hold(hold), .flush(flush),
    .stall(a_stall), .ex_valid(a_ex_valid), .ex_rs_v(a_ex_rs_v), .ex_fwd(a_ex_fwd),
    .stall_cnt(a_stall_cnt), .err(a_err));

  bypass_ctrl #(.XLEN(32), .NSRC(2), .NSTAGE(2), .FWD_EN(0), .STALL_MAX(4)) dut_b (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs_s(id_rs_s), .id_rs_use(id_rs_use),
    .id_rs_v(id_rs_v), .byp_valid(byp_valid), .byp_regf_we(byp_regf_we), .byp_rd_s(byp_rd_s),
    .byp_ready(byp_ready), .byp_data(byp_data), .hold(hold), .flush(flush),
    .stall(b_stall), .ex_valid(b_ex_valid), .ex_rs_v(b_ex_rs_v), .ex_fwd(b_ex_fwd),
    .stall_cnt(b_stall_cnt), .err(b_err));

  // Kinds: 0 a_stall, 1 a_ex_valid, 2 a_ex_rs_v, 3 a_ex_fwd, 4 a_stall_cnt, 5 a_err,
  //        6 b_stall, 7 b_ex_valid, 8 b_ex_rs_v, 9 b_ex_fwd
  typedef struct {
    int          cyc;
    int          kind;
    logic [63:0] val;
    string       name;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] actual(input int kind);
    case (kind)
      0: return {63'd0, a_stall};
      1: return {63'd0, a_ex_valid};
      2: return a_ex_rs_v;
      3: return {62'd0, a_ex_fwd};
      4: return {32'd0, a_stall_cnt};
      5: return {63'd0, a_err};
      6: return {63'd0, b_stall};
      7: return {63'd0, b_ex_valid};
      8: return b_ex_rs_v;
      default: return {62'd0, b_ex_fwd};
    endcase
  endfunction

  always @(negedge clk) begin
    int i;
    logic [63:0] act;
    i = 0;
    while (i < sbq.size()) begin
      if (sbq[i].cyc < cyc) begin
        total_cnt++;
        $display("FAIL %s: expectation for cycle %0d never checked (now %0d)",
                 sbq[i].name, sbq[i].cyc, cyc);
        sbq.delete(i);
      end else if (sbq[i].cyc == cyc) begin
        act = actual(sbq[i].kind);
        total_cnt++;
        if (act === sbq[i].val) begin
          pass_cnt++;
          $display("cyc %0d %s: got 0x%0h ok", cyc, sbq[i].name, act);
        end else begin
          $display("FAIL %s: cyc %0d got 0x%0h required 0x%0h", sbq[i].name, cyc, act, sbq[i].val);
        end
        sbq.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic chk(input int kind, input logic [63:0] val, input string name, input int dly);
    exp_t e;
    e.cyc  = cyc + dly;
    e.kind = kind;
    e.val  = val;
    e.name = name;
    sbq.push_back(e);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid    = 1'b0;
    id_rs_s     = '0;
    id_rs_use   = '0;
    id_rs_v     = '0;
    byp_valid   = '0;
    byp_regf_we = '0;
    byp_rd_s    = '0;
    byp_ready   = '0;
    byp_data    = '0;
    hold        = 1'b0;
    flush       = 1'b0;
  endtask

  task automatic op(input int i, input logic [4:0] rs, input logic u, input logic [31:0] v);
    id_rs_s[5*i +: 5]   = rs;
    id_rs_use[i]        = u;
    id_rs_v[32*i +: 32] = v;
  endtask

  task automatic stg(input int k, input logic v, input logic we, input logic [4:0] rd,
                     input logic rdy, input logic [31:0] d);
    byp_valid[k]         = v;
    byp_regf_we[k]       = we;
    byp_rd_s[5*k +: 5]   = rd;
    byp_ready[k]         = rdy;
    byp_data[32*k +: 32] = d;
  endtask

  task automatic do_reset();
    idle();
    next();
    rst = 1'b1;
    chk(0, 64'd0, "rst_a_stall", 0);
    chk(1, 64'd0, "rst_a_ex_valid", 0);
    chk(2, 64'd0, "rst_a_ex_rs_v", 0);
    chk(3, 64'd0, "rst_a_ex_fwd", 0);
    chk(4, 64'd0, "rst_a_stall_cnt", 0);
    chk(5, 64'd0, "rst_a_err", 0);
    chk(7, 64'd0, "rst_b_ex_valid", 0);
    chk(8, 64'd0, "rst_b_ex_rs_v", 0);
    next();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    do_reset();

    // Youngest producer wins over an older one with the same rd.
    id_valid = 1'b1;
    op(0, 5'd5, 1'b1, 32'hDEAD);
    op(1, 5'd9, 1'b1, 32'h9999);
    stg(0, 1'b1, 1'b1, 5'd5, 1'b1, 32'hAAAA0000);
    stg(1, 1'b1, 1'b1, 5'd5, 1'b1, 32'h1111);
    chk(0, 64'd0, "s1_a_stall", 0);
    chk(6, 64'd1, "s1_b_stall_young", 0);
    chk(1, 64'd1, "s1_ex_valid", 1);
    chk(2, {32'h9999, 32'hAAAA0000}, "s1_youngest_wins", 1);
    chk(3, 64'd1, "s1_ex_fwd", 1);
    next();
    idle();
    chk(1, 64'd0, "s1_bubble_idle", 1);
    next();

    // Load-use: one bubble, then forward from MEM/WB.
    do_reset();
    id_valid = 1'b1;
    op(0, 5'd2, 1'b1, 32'h22);
    op(1, 5'd7, 1'b1, 32'h77);
    stg(0, 1'b1, 1'b1, 5'd7, 1'b0, 32'hBAD);
    chk(0, 64'd1, "s2_load_stall", 0);
    chk(1, 64'd0, "s2_bubble", 1);
    chk(4, 64'd1, "s2_stall_cnt", 1);
    next();
    stg(0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0);
    stg(1, 1'b1, 1'b1, 5'd7, 1'b1, 32'h55);
    chk(0, 64'd0, "s2_no_stall", 0);
    chk(1, 64'd1, "s2_ex_valid", 1);
    chk(2, {32'h55, 32'h22}, "s2_load_fwd", 1);
    chk(3, 64'd2, "s2_ex_fwd", 1);
    chk(4, 64'd1, "s2_stall_cnt_kept", 1);
    next();

    // WB-only bypass instance, plus x0 never matching.
    do_reset();
    id_valid = 1'b1;
    op(0, 5'd3, 1'b1, 32'h33);
    op(1, 5'd0, 1'b1, 32'h44);
    stg(0, 1'b1, 1'b1, 5'd3, 1'b1, 32'h300);
    stg(1, 1'b1, 1'b1, 5'd0, 1'b1, 32'hF0F0);
    chk(6, 64'd1, "s3_b_stall", 0);
    chk(0, 64'd0, "s3_a_stall", 0);
    chk(7, 64'd0, "s3_b_bubble", 1);
    chk(2, {32'h44, 32'h300}, "s3_a_x0_regfile", 1);
    chk(3, 64'd1, "s3_a_ex_fwd", 1);
    next();
    stg(0, 1'b1, 1'b1, 5'd0, 1'b0, 32'hBAD);
    stg(1, 1'b1, 1'b1, 5'd3, 1'b1, 32'h300);
    chk(6, 64'd0, "s3_b_no_stall", 0);
    chk(0, 64'd0, "s3_a_x0_no_stall", 0);
    chk(7, 64'd1, "s3_b_ex_valid", 1);
    chk(8, {32'h44, 32'h300}, "s3_b_fwd_stage1", 1);
    chk(9, 64'd1, "s3_b_ex_fwd", 1);
    next();

    // Hold freezes ID/EX; stalls under hold feed the watchdog only; flush beats hold.
    do_reset();
    id_valid = 1'b1;
    op(0, 5'd1, 1'b1, 32'h1234);
    op(1, 5'd2, 1'b1, 32'h5678);
    chk(0, 64'd0, "s4_stall", 0);
    chk(1, 64'd1, "s4_capture", 1);
    chk(2, {32'h5678, 32'h1234}, "s4_capture_rs", 1);
    next();
    for (int j = 0; j < 3; j++) begin
      hold = 1'b1;
      op(0, 5'd1, 1'b1, 32'hFFFF + j);
      stg(0, 1'b1, 1'b1, 5'd1, 1'b0, 32'h0);
      chk(0, 64'd1, "s4_stall_in_hold", 0);
      chk(1, 64'd1, "s4_hold_valid", 1);
      chk(2, {32'h5678, 32'h1234}, "s4_hold_rs", 1);
      chk(4, 64'd0, "s4_hold_cnt", 1);
      next();
    end
    flush = 1'b1;
    chk(1, 64'd0, "s4_flush_over_hold", 1);
    chk(2, 64'd0, "s4_flush_rs", 1);
    chk(4, 64'd0, "s4_flush_cnt", 1);
    chk(5, 64'd1, "s4_err_run_during_hold", 1);
    next();

    // Watchdog sets after STALL_MAX stalls, is sticky, and async reset clears it.
    do_reset();
    id_valid = 1'b1;
    op(0, 5'd4, 1'b1, 32'h40);
    op(1, 5'd0, 1'b0, 32'h0);
    stg(0, 1'b1, 1'b1, 5'd4, 1'b0, 32'h0);
    for (int j = 0; j < 4; j++) begin
      chk(0, 64'd1, "s5_stall", 0);
      chk(5, (j == 3) ? 64'd1 : 64'd0, "s5_err", 1);
      chk(4, 64'(j + 1), "s5_stall_cnt", 1);
      next();
    end
    stg(0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0);
    chk(0, 64'd0, "s5_stall_clear", 0);
    chk(5, 64'd1, "s5_err_sticky", 1);
    chk(1, 64'd1, "s5_capture", 1);
    chk(2, 64'h40, "s5_capture_rs", 1);
    chk(4, 64'd4, "s5_cnt_kept", 1);
    next();
    stg(0, 1'b1, 1'b1, 5'd4, 1'b0, 32'h0);
    chk(0, 64'd1, "s5_stall_again", 0);
    next();
    rst = 1'b1;
    chk(0, 64'd1, "s5_rst_stall_follows", 0);
    chk(1, 64'd0, "s5_rst_ex_valid", 0);
    chk(2, 64'd0, "s5_rst_ex_rs_v", 0);
    chk(4, 64'd0, "s5_rst_stall_cnt", 0);
    chk(5, 64'd0, "s5_rst_err", 0);
    next();
    rst = 1'b0;

    // Unused operand never stalls; flush beats capture.
    do_reset();
    id_valid = 1'b1;
    op(0, 5'd6, 1'b0, 32'h66);
    op(1, 5'd8, 1'b1, 32'h88);
    stg(0, 1'b1, 1'b1, 5'd6, 1'b0, 32'h0);
    chk(0, 64'd0, "s6_unused_no_stall", 0);
    chk(1, 64'd1, "s6_ex_valid", 1);
    chk(2, {32'h88, 32'h66}, "s6_regfile_rs", 1);
    chk(3, 64'd0, "s6_ex_fwd", 1);
    next();
    flush = 1'b1;
    chk(1, 64'd0, "s6_flush_over_capture", 1);
    next();
    idle();
    next();
    next();

    total_cnt++;
    if (sbq.size() == 0) pass_cnt++;
    else $display("FAIL leftover: %0d expectations unchecked, required 0", sbq.size());

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
